// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit RISC CPU: the machine word width, the
// word-address and instruction typedefs, the NOP encoding and a PC helper.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] addr_t;
   typedef logic [WORD_W-1:0] instr_t;

   localparam instr_t NOP_INSTR = 16'h0000;

   // Sequential successor of a word address; wraps 16'hFFFF to 16'h0000.
   function automatic addr_t pc_next(input addr_t pc);
      return pc + 16'h0001;
   endfunction

endpackage

// File: rtl/fetch_rom.sv
// ---------------------------------------------------------------------------
// fetch_rom
// Word-addressed synchronous instruction ROM with a registered, enabled read
// port. Addresses beyond the populated depth return NOP rather than aliasing.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset (clears the read register)
//   en_i    in   read enable; when low the read register holds
//   addr_i  in   word address (16 bit)
//   data_o  out  registered read data (16 bit)
// ---------------------------------------------------------------------------
module fetch_rom
   import cpu_pkg::*;
#(
   parameter int    IMEM_DEPTH = 256,
   parameter string INIT_FILE  = ""
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  en_i,
   input  addr_t addr_i,
   output instr_t data_o
);

   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   instr_t rom_mem [IMEM_DEPTH];
   instr_t rd_data_s;
   logic   in_range_s;
   instr_t data_q;
   instr_t data_d;

   // Elaboration-time ROM image: zero fill.
   initial begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
         rom_mem[i] = NOP_INSTR;
      end
   end

   // Array lookup with out-of-range guard; the 32-bit compare also covers a
   // full 64K-word ROM where every address is in range.
   always_comb begin
      in_range_s = (32'(addr_i) < 32'(IMEM_DEPTH));
      data_d     = data_q;
      rd_data_s  = NOP_INSTR;
      if (in_range_s) begin
         rd_data_s = rom_mem[addr_i[AW-1:0]];
      end else begin
         rd_data_s = NOP_INSTR;
      end
      if (en_i) begin
         data_d = rd_data_s;
      end else begin
         data_d = data_q;
      end
   end

   // Read data register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= NOP_INSTR;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: program counter with jump (call) and return,
// a return-address stack, and the instruction ROM read at the current PC.
// Both outputs come straight from registers.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   jump_enable    in   load PC from jump_address, push PC+1
//   jump_address   in   jump/call target word address (16 bit)
//   return_enable  in   pop return stack into PC (increment if empty)
//   imem_enable    in   ROM read enable
//   counter_reg    out  current PC (16 bit)
//   instruction    out  registered ROM data, one cycle behind counter_reg
// ---------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int    IMEM_DEPTH  = 256,
   parameter int    STACK_DEPTH = 4,
   parameter string INIT_FILE   = ""
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               jump_enable,
   input  logic [WORD_W-1:0]  jump_address,
   input  logic               return_enable,
   input  logic               imem_enable,
   output logic [WORD_W-1:0]  counter_reg,
   output logic [WORD_W-1:0]  instruction
);

   // Pointer counts valid entries, so it needs to reach STACK_DEPTH itself.
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   addr_t          pc_q,    pc_d;
   addr_t          stack_q [STACK_DEPTH];
   addr_t          stack_d [STACK_DEPTH];
   logic [SPW-1:0] sp_q,    sp_d;
   addr_t          pc_plus1_s;
   addr_t          tos_s;
   logic           do_return_s;

   // PC and return-stack next state: return > jump > increment.
   always_comb begin
      pc_plus1_s  = pc_next(pc_q);
      pc_d        = pc_plus1_s;
      sp_d        = sp_q;
      tos_s       = 16'h0000;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         stack_d[i] = stack_q[i];
         if (SPW'(i) == (sp_q - SPW'(1))) begin
            tos_s = stack_q[i];
         end else begin
            tos_s = tos_s;
         end
      end
      do_return_s = return_enable && (sp_q != '0);

      if (do_return_s) begin
         pc_d = tos_s;
         sp_d = sp_q - SPW'(1);
      end else if (jump_enable && !return_enable) begin
         // A return request with an empty stack still suppresses the jump.
         pc_d = jump_address;
         if (sp_q == SP_FULL) begin
            // Full: drop the oldest entry (index 0) and append at the top.
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
               stack_d[i] = stack_q[i+1];
            end
            stack_d[STACK_DEPTH-1] = pc_plus1_s;
            sp_d = sp_q;
         end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
               if (SPW'(i) == sp_q) begin
                  stack_d[i] = pc_plus1_s;
               end else begin
                  stack_d[i] = stack_q[i];
               end
            end
            sp_d = sp_q + SPW'(1);
         end
      end else begin
         pc_d = pc_plus1_s;
      end
   end

   // PC and return-stack registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= 16'h0000;
         sp_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= 16'h0000;
         end
      end else begin
         pc_q <= pc_d;
         sp_q <= sp_d;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   // ROM is addressed by the pre-edge PC, so instruction trails counter_reg.
   fetch_rom #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .INIT_FILE  (INIT_FILE)
   ) u_rom (
      .clk_i  (clk),
      .rst_i  (reset),
      .en_i   (imem_enable),
      .addr_i (pc_q),
      .data_o (instruction)
   );

   assign counter_reg = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int DEPTH  = 256;
   localparam int SDEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        jump_enable;
   logic [15:0] jump_address;
   logic        return_enable;
   logic        imem_enable;
   logic [15:0] counter_reg;
   logic [15:0] instruction;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_stk[$];
   logic [15:0] m_pc;
   logic [15:0] m_instr;
   int          checks   = 0;
   int          failures = 0;

   fetch_unit #(
      .IMEM_DEPTH  (DEPTH),
      .STACK_DEPTH (SDEPTH),
      .INIT_FILE   ("")
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .jump_enable   (jump_enable),
      .jump_address  (jump_address),
      .return_enable (return_enable),
      .imem_enable   (imem_enable),
      .counter_reg   (counter_reg),
      .instruction   (instruction)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_mem(input logic [15:0] a);
      if (32'(a) < DEPTH) return 16'h1000 + a;
      return 16'h0000;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, push expectation, compare.
   task automatic step(input logic j, input logic [15:0] ja, input logic r,
                       input logic en, input string tag);
      logic [15:0] old_pc;
      exp_t        e;
      jump_enable   = j;
      jump_address  = ja;
      return_enable = r;
      imem_enable   = en;
      old_pc = m_pc;
      if (en) m_instr = exp_mem(old_pc);
      if (r && m_stk.size() > 0) begin
         m_pc = m_stk.pop_back();
      end else if (j && !r) begin
         if (m_stk.size() == SDEPTH) void'(m_stk.pop_front());
         m_stk.push_back(old_pc + 16'd1);
         m_pc = ja;
      end else begin
         m_pc = old_pc + 16'd1;
      end
      sb.push_back('{pc: m_pc, instr: m_instr});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({tag, "_pc"}, counter_reg, e.pc);
      check({tag, "_instr"}, instruction, e.instr);
      jump_enable   = 1'b0;
      return_enable = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_pc", counter_reg, 16'h0000);
      check("rst_instr", instruction, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = 16'h0000;
      m_instr = 16'h0000;
      m_stk.delete();
   endtask

   initial begin
      reset         = 1'b1;
      jump_enable   = 1'b0;
      jump_address  = 16'h0000;
      return_enable = 1'b0;
      imem_enable   = 1'b1;
      m_pc          = 16'h0000;
      m_instr       = 16'h0000;
      #1;
      for (int i = 0; i < DEPTH; i++) dut.u_rom.rom_mem[i] = 16'h1000 + 16'(i);

      // 1: reset then free run
      @(posedge clk);
      #1;
      check("init_pc", counter_reg, 16'h0000);
      check("init_instr", instruction, 16'h0000);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, "run");

      // 2: jump / return
      do_reset();
      step(1'b1, 16'h0004, 1'b0, 1'b1, "jmp4");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "jmp_seq");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "jmp_seq");
      step(1'b0, 16'h0000, 1'b1, 1'b1, "ret1");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "after_ret");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "after_ret");

      // 3: enable gating
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, "gate_off");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "gate_on");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "gate_on");

      // 4: stack corner cases
      step(1'b0, 16'h0000, 1'b1, 1'b1, "ret_empty");
      for (int i = 1; i <= 5; i++) step(1'b1, 16'(20 * i), 1'b0, 1'b1, "nest_jmp");
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1, 1'b1, "nest_ret");
      step(1'b1, 16'h00C8, 1'b0, 1'b1, "call200");
      step(1'b1, 16'h0032, 1'b1, 1'b1, "jmp_and_ret");
      step(1'b0, 16'h0000, 1'b1, 1'b1, "ret_after_both");

      // 5: boundaries
      step(1'b1, 16'hFFFF, 1'b0, 1'b1, "jmp_ffff");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "wrap");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "wrap_next");
      step(1'b1, 16'(DEPTH + 3), 1'b0, 1'b1, "jmp_oor");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "oor_read");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "oor_read2");

      // 6: async reset mid-cycle at PC = 7 with a non-empty stack
      do_reset();
      step(1'b0, 16'h0000, 1'b0, 1'b1, "pre7");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "pre7");
      step(1'b1, 16'h0006, 1'b0, 1'b1, "pre7_jmp");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "at7");
      #3;
      reset = 1'b1;
      #1;
      check("async_pc", counter_reg, 16'h0000);
      check("async_instr", instruction, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = 16'h0000;
      m_instr = 16'h0000;
      m_stk.delete();
      step(1'b0, 16'h0000, 1'b1, 1'b1, "ret_post_reset");
      step(1'b0, 16'h0000, 1'b0, 1'b1, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
